seq_restoring_divider: RTL and testbench

//  Unsigned iterative divider. Takes a dividend/divisor pair; returns quotient and remainder.

---
 rtl/div_pkg.sv | 24 ++
 rtl/borrow_chain_sub.sv | 36 +++
 rtl/seq_restoring_divider.sv | 122 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value - 1;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/borrow_chain_sub.sv
// Combinational a-b with borrow out, built from two-bit carry-chain cells (a + ~b + 1).
// Latency 0; no flow control.
module borrow_chain_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int CELLS = (N + 1) / 2;

  logic [CELLS:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    if (2 * i + 1 < N) begin : g_pair
      logic [2:0] sum;
      assign sum = {1'b0, a[2*i+1:2*i]} + {1'b0, ~b[2*i+1:2*i]} + {2'b00, carry[i]};
      assign diff[2*i+1:2*i] = sum[1:0];
      assign carry[i+1] = sum[2];
    end else begin : g_single
      // Odd N: the top cell only uses its low half.
      logic [1:0] sum;
      assign sum = {1'b0, a[2*i]} + {1'b0, ~b[2*i]} + {1'b0, carry[i]};
      assign diff[2*i] = sum[0];
      assign carry[i+1] = sum[1];
    end
  end

  // Carry out of a + ~b + 1 is the inverse of the borrow.
  assign borrow_out = ~carry[CELLS];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned radix-2 restoring divider: WIDTH+1 clocks accept-to-valid (1 clock for divide by zero).
// Result held until out_valid && out_ready; operands accepted only in IDLE, the cycle after a handshake at the earliest.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CNT_W = clog2(DIV_WIDTH_DEFAULT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state;
  div_state_t state_nxt;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             borrow;
  logic             q_bit;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign accept       = in_valid && in_ready;
  assign divisor_zero = (divisor == '0);

  assign trial_a = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial_b = {1'b0, d};

  borrow_chain_sub #(
    .N (WIDTH + 1)
  ) u_borrow_chain (
    .a          (trial_a),
    .b          (trial_b),
    .diff       (trial_diff),
    .borrow_out (borrow)
  );

  // r[WIDTH] is zero between iterations; OR-ing it in keeps the quotient bit
  // correct even if the shifted partial remainder ever spilled past the chain.
  assign q_bit = r[WIDTH] | ~borrow;
  assign r_nxt = q_bit ? trial_diff : trial_a;
  assign q_nxt = {q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = divisor_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r   <= '0;
              q   <= dividend;
              d   <= divisor;
              cnt <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          r <= r_nxt;
          q <= q_nxt;
          if (cnt == '0) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider at WIDTH=16 (directed + random) and WIDTH=8 (random).
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  // WIDTH=16 instance
  logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1, a_dz;
  logic [15:0] a_n = '0, a_d = '0, a_q, a_r;
  // WIDTH=8 instance
  logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1, b_dz;
  logic [7:0]  b_n = '0, b_d = '0, b_q, b_r;

  seq_restoring_divider #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .dividend(a_n), .divisor(a_d),
    .out_valid(a_ov), .out_ready(a_or), .quotient(a_q), .remainder(a_r), .div_by_zero(a_dz));

  seq_restoring_divider #(.WIDTH(8), .CNT_W(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .dividend(b_n), .divisor(b_d),
    .out_valid(b_ov), .out_ready(b_or), .quotient(b_q), .remainder(b_r), .div_by_zero(b_dz));

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, k, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding division per instance, result from / and %.
  bit          m_busy [2];
  int          m_done [2];
  logic [15:0] m_q    [2];
  logic [15:0] m_r    [2];
  logic        m_z    [2];

  task automatic model_step(input int k, input int w, input logic rst_i, input logic iv,
                            input logic ordy, input logic [15:0] n, input logic [15:0] dv,
                            input logic ir, input logic ov, input logic [15:0] q,
                            input logic [15:0] r, input logic dz);
    logic [15:0] mask;
    bit exp_ov;
    mask   = 16'((32'd1 << w) - 1);
    exp_ov = m_busy[k] && (cyc >= m_done[k]);
    chk("in_ready", k, ir, !m_busy[k]);
    chk("out_valid", k, ov, exp_ov);
    if (exp_ov) begin
      chk("quotient", k, q, m_q[k]);
      chk("remainder", k, r, m_r[k]);
      chk("div_by_zero", k, dz, m_z[k]);
    end
    if (rst_i) begin
      m_busy[k] = 1'b0;
    end else if (exp_ov && ordy) begin
      m_busy[k] = 1'b0;
    end else if (!m_busy[k] && iv) begin
      m_busy[k] = 1'b1;
      if (dv == 16'd0) begin
        m_q[k] = mask;
        m_r[k] = n;
        m_z[k] = 1'b1;
        m_done[k] = cyc + 1;
      end else begin
        m_q[k] = n / dv;
        m_r[k] = n % dv;
        m_z[k] = 1'b0;
        m_done[k] = cyc + w + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      model_step(0, 16, rst, a_iv, a_or, a_n, a_d, a_ir, a_ov, a_q, a_r, a_dz);
      model_step(1, 8, rst, b_iv, b_or, {8'd0, b_n}, {8'd0, b_d}, b_ir, b_ov,
                 {8'd0, b_q}, {8'd0, b_r}, b_dz);
    end
  end

  int acc_cyc;

  task automatic issue(input logic [15:0] n, input logic [15:0] dv);
    int t;
    t = 0;
    a_n = n;
    a_d = dv;
    a_iv = 1'b1;
    while (a_ir !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_timeout", 0, (t < 100), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    a_iv = 1'b0;
    a_n = 16'($urandom);
    a_d = 16'($urandom);
  endtask

  task automatic result(input string tag, input int lat_exp, input logic [15:0] q_exp,
                        input logic [15:0] r_exp, input logic z_exp);
    int t;
    int lat;
    t = 0;
    while (a_ov !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    lat = (a_ov === 1'b1) ? cyc + 1 - acc_cyc : -1;
    chk({tag, "_latency"}, 0, lat, lat_exp);
    chk({tag, "_quotient"}, 0, a_q, q_exp);
    chk({tag, "_remainder"}, 0, a_r, r_exp);
    chk({tag, "_div_by_zero"}, 0, a_dz, z_exp);
  endtask

  task automatic rand_drive16(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      a_iv = ($urandom_range(0, 1) == 0);
      a_n  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a_d = 16'd0;
        1: a_d = 16'd1;
        2: a_d = 16'($urandom_range(1, 15));
        3: a_d = a_n;
        default: a_d = 16'($urandom);
      endcase
      a_or = ($urandom_range(0, 3) != 0);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
  endtask

  task automatic rand_drive8(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      b_iv = ($urandom_range(0, 1) == 0);
      b_n  = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b_d = 8'd0;
        1: b_d = 8'd1;
        2: b_d = 8'($urandom_range(1, 7));
        3: b_d = b_n;
        default: b_d = 8'($urandom);
      endcase
      b_or = ($urandom_range(0, 3) != 0);
    end
    b_iv = 1'b0;
    b_or = 1'b1;
  endtask

  initial begin
    int hs;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_quotient", 0, a_q, 0);
    chk("rst_remainder", 0, a_r, 0);
    chk("rst_div_by_zero", 0, a_dz, 0);
    chk("rst_in_ready", 0, a_ir, 1);
    chk("rst_out_valid", 0, a_ov, 0);

    // 1000 / 7
    issue(16'd1000, 16'd7);
    result("t1", 17, 16'd142, 16'd6, 1'b0);
    @(posedge clk); #1;
    chk("t1_valid_drop", 0, a_ov, 0);

    // divide by zero
    issue(16'hFFFF, 16'd0);
    result("t2", 1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;

    // 5 / 9 under backpressure
    a_or = 1'b0;
    issue(16'd5, 16'd9);
    result("t3", 17, 16'd0, 16'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_quotient", 0, a_q, 0);
      chk("t3_hold_remainder", 0, a_r, 5);
      chk("t3_hold_in_ready", 0, a_ir, 0);
      chk("t3_hold_out_valid", 0, a_ov, 1);
    end
    a_or = 1'b1;
    @(posedge clk); #1;
    chk("t3_after_hs_out_valid", 0, a_ov, 0);
    chk("t3_after_hs_in_ready", 0, a_ir, 1);

    // all-ones / all-ones, then all-ones / 1 immediately after
    issue(16'hFFFF, 16'hFFFF);
    result("t4a", 17, 16'd1, 16'd0, 1'b0);
    @(posedge clk); #1;
    hs = cyc;
    issue(16'hFFFF, 16'd1);
    chk("t4_accept_gap", 0, acc_cyc - hs, 1);
    result("t4b", 17, 16'hFFFF, 16'd0, 1'b0);
    @(posedge clk); #1;

    // abort mid-division with reset, then reissue
    issue(16'd40000, 16'd3);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_abort_out_valid", 0, a_ov, 0);
    chk("t5_abort_in_ready", 0, a_ir, 1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("t5_no_stale_valid", 0, a_ov, 0);
    issue(16'd40000, 16'd3);
    result("t5", 17, 16'd13333, 16'd1, 1'b0);
    @(posedge clk); #1;

    fork
      rand_drive16(20000);
      rand_drive8(20000);
    join
    repeat (40) @(posedge clk);
    #1;
    chk("drain_out_valid16", 0, a_ov, 0);
    chk("drain_out_valid8", 1, b_ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
